decode_stage: RTL and testbench
===============================

# decode_stage

Registered, handshaked successor to the combinational control decoder: it accepts one RV32/RV64 instruction per cycle from fetch, decodes register-file, data-memory, MUL/DIV and PIM/DMA controls, and holds them in an output register for execute. It also owns the issue interlocks for the multi-cycle MUL/DIV unit and the PIM DMA engine, and supports flush. Strobe width scales with `XLEN`.

## Interface
- `XLEN`, 32: datapath width, 32 or 64; `STRB_W = XLEN/8`.
- `MULDIV_LAT`, 4: cycles the MUL/DIV unit stays busy after issue, ≥1.
- `PIM_OPCODE`, 7'b0001011: custom-0 opcode for PIM/DMA commands.
- `clk_i` in 1: clock; all state on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `in_valid_i` in 1 / `in_ready_o` out 1: fetch handshake.
- `instr_i` in 32: instruction word.
- `flush_i` in 1: discard held and incoming instruction.
- `dma_done_i` in 1: single-cycle pulse ending a DMA command.
- `out_valid_o` out 1 / `out_ready_i` in 1: execute handshake.
- `rd_o` out 5, `rs1_o` out 5, `funct3_o` out 3: registered instruction fields.
- `reg_write_o` out 1, `mem_read_o` out 1, `mem_write_o` out 1.
- `d_size_o` out `STRB_W`: byte-strobe mask.
- `d_unsigned_o` out 1; `mem_to_reg_o` out 3: 000 ALU, 001 DMEM, 010 PC+4, 011 IMM, 101 MUL.
- `muldiv_en_o` out 1, `dma_en_o` out 1, `illegal_o` out 1.
- `busy_o` out 1: MUL/DIV counter nonzero or DMA outstanding.

## Operation
- Decode mapping: R → reg_write, ALU; funct7 0000001 → MUL source, muldiv_en. OP-IMM → reg_write, ALU. LOAD → mem_read, reg_write, DMEM. STORE → mem_write. JAL/JALR → reg_write, PC+4. AUIPC → ALU. LUI → IMM. BRANCH → all controls 0, legal.
- Strobes: funct3[1:0] = 00 → 1; 01 → 3; 10 → 0xF; 11 → all ones, legal only when `XLEN`=64.
- Unsigned: funct3[2]=1 on a load sets `d_unsigned_o`. LWU (110) is legal only when `XLEN`=64.
- Illegal encodings: unknown opcode or illegal funct3 sets `illegal_o`=1 and forces every other control to 0. The instruction is still passed downstream.
- rd = x0: `reg_write_o` forced to 0.
- Output register: `vld_q`, loaded on in_valid_i && in_ready_o, cleared on a downstream transfer without a new load.
- `in_ready_o = !flush_i && (!vld_q || (out_valid_o && out_ready_i))`.
- `out_valid_o = vld_q && !busy_o`.
- MUL/DIV interlock: when a transfer carries muldiv_en, `mdcnt` loads `MULDIV_LAT`, then decrements to 0 each cycle.
- DMA interlock: when a transfer carries dma_en, `dma_busy` sets; `dma_done_i` clears it.
- `flush_i` clears `vld_q` only. Interlocks keep running because the units are already active.
- Flush has priority over a same-cycle load or transfer.

## Timing
- Reset: every output 0 except `in_ready_o`, which is 1 when `flush_i`=0. `vld_q`, `mdcnt` and `dma_busy` reset to 0.
- Latency: 1 cycle from acceptance to `out_valid_o`, given `busy_o`=0. Throughput is 1 instruction per cycle with `out_ready_i` held high.
- After a MUL/DIV transfer at cycle T, the next `out_valid_o` rises at T+`MULDIV_LAT`+1 at the earliest.
- After a DMA transfer, `out_valid_o` stays low until the cycle after `dma_done_i`.
- `dma_done_i` arriving in the same cycle as a new DMA transfer: the set wins.
- Outputs are stable while `out_valid_o && !out_ready_i`.
- Reset asserted mid-stall drops all state immediately.

## Configuration
- `DECODE_PIM_DMA_EN` defined: `PIM_OPCODE` decodes to dma_en=1 and mem_write=1, and the DMA interlock is built.
- `DECODE_PIM_DMA_EN` undefined: `PIM_OPCODE` is illegal, `dma_busy` is tied to 0, and `dma_done_i` is ignored.

## Test plan
- Reset, then `lw x5,0(x1)` (0x0000A283) with out_ready=1 → next cycle: out_valid=1, mem_read=1, reg_write=1, d_size=0xF, mem_to_reg=001, rd=5.
- `mul x3,x1,x2` (0x022081B3) followed by an add, `MULDIV_LAT`=4 → mul transfers at T; the add is presented with out_valid=1 at T+5; busy_o=1 for cycles T+1..T+4.
- `addi x0,x0,0` (0x00000013) → reg_write=0, illegal=0. Opcode 0x7F → illegal=1 and all controls 0.
- `XLEN`=64, `ld` (funct3 011) → d_size=0xFF. Same instruction with `XLEN`=32 → illegal=1.
- Macro defined, PIM instruction, then `dma_done_i` pulsed 10 cycles later → dma_en=1 and mem_write=1; the next instruction is held until the cycle after the pulse. Macro undefined → the PIM instruction gives illegal=1.
- Valid held, out_ready=0, then flush_i pulsed → out_valid drops the next cycle, in_ready_o=0 during the flush, and a concurrently offered instruction is not accepted.

Source files
------------

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//
// Registered, handshaked instruction decoder sitting between fetch and
// execute. One RV32/RV64 instruction is accepted per cycle. It is decoded into
// register-file, data-memory, MUL/DIV and PIM/DMA controls, which are held in
// an output register until execute takes them. The stage also owns the issue
// interlocks for the multi-cycle MUL/DIV unit and for the PIM DMA engine.
//
// Parameters
//   XLEN        datapath width, 32 or 64. Strobe width is STRB_W = XLEN/8.
//   MULDIV_LAT  number of cycles the MUL/DIV unit stays busy after issue (>= 1).
//   PIM_OPCODE  custom opcode carrying PIM/DMA commands.
//
// Optional feature (compile-time macro DECODE_PIM_DMA_EN)
//   defined   : PIM_OPCODE decodes to dma_en=1 and mem_write=1. The DMA
//               interlock is built and is cleared by dma_done_i.
//   undefined : PIM_OPCODE is an illegal encoding. The DMA interlock is tied
//               off and dma_done_i is ignored.
//
// Ports
//   clk_i, rst_ni            clock (rising edge); asynchronous active-low reset
//   in_valid_i / in_ready_o  fetch handshake
//   instr_i                  32-bit instruction word
//   flush_i                  drop the held instruction and refuse the incoming one
//   dma_done_i               single-cycle pulse that ends an outstanding DMA command
//   out_valid_o/out_ready_i  execute handshake
//   rd_o, rs1_o, funct3_o    registered instruction fields
//   reg_write_o, mem_read_o, mem_write_o, d_size_o, d_unsigned_o,
//   mem_to_reg_o (000 ALU, 001 DMEM, 010 PC+4, 011 IMM, 101 MUL),
//   muldiv_en_o, dma_en_o, illegal_o   registered decode controls
//   busy_o                   MUL/DIV countdown running or DMA outstanding
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and its data stable until that edge.
// in_ready_o depends combinationally on out_ready_i and flush_i, so the stage
// can load a new instruction on the same edge that it hands one downstream.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int         XLEN       = 32,
  parameter int         MULDIV_LAT = 4,
  parameter logic [6:0] PIM_OPCODE = 7'b0001011
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [31:0]           instr_i,
  input  logic                  flush_i,
  input  logic                  dma_done_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [4:0]            rd_o,
  output logic [4:0]            rs1_o,
  output logic [2:0]            funct3_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [XLEN/8-1:0]     d_size_o,
  output logic                  d_unsigned_o,
  output logic [2:0]            mem_to_reg_o,
  output logic                  muldiv_en_o,
  output logic                  dma_en_o,
  output logic                  illegal_o,
  output logic                  busy_o
);

  localparam int STRB_W = XLEN / 8;
  localparam int CNT_W  = $clog2(MULDIV_LAT + 1);

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Write-back source select
  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_DMEM = 3'b001;
  localparam logic [2:0] WB_PC4  = 3'b010;
  localparam logic [2:0] WB_IMM  = 3'b011;
  localparam logic [2:0] WB_MUL  = 3'b101;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] unused_rs2;

  assign opcode     = instr_i[6:0];
  assign rd         = instr_i[11:7];
  assign funct3     = instr_i[14:12];
  assign rs1        = instr_i[19:15];
  assign unused_rs2 = instr_i[24:20];
  assign funct7     = instr_i[31:25];

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic              dec_rw;
  logic              dec_mr;
  logic              dec_mw;
  logic [STRB_W-1:0] dec_size;
  logic              dec_uns;
  logic [2:0]        dec_m2r;
  logic              dec_md;
  logic              dec_dma;
  logic              dec_ill;
  logic [STRB_W-1:0] strb;

  // Byte strobe implied by funct3[1:0]. The doubleword case is only reachable
  // on a legal access when XLEN is 64; the illegal check below handles RV32.
  always_comb begin
    strb = '0;
    case (funct3[1:0])
      2'b00:   strb = STRB_W'(1);
      2'b01:   strb = STRB_W'(3);
      2'b10:   strb = STRB_W'(15);
      default: strb = {STRB_W{1'b1}};
    endcase
  end

  always_comb begin
    dec_rw   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_size = '0;
    dec_uns  = 1'b0;
    dec_m2r  = WB_ALU;
    dec_md   = 1'b0;
    dec_dma  = 1'b0;
    dec_ill  = 1'b0;

    case (opcode)
      OPC_OP: begin
        dec_rw = 1'b1;
        if (funct7 == FUNCT7_MULDIV) begin
          dec_m2r = WB_MUL;
          dec_md  = 1'b1;
        end
      end
      OPC_OP_IMM: dec_rw = 1'b1;
      OPC_LOAD: begin
        dec_mr   = 1'b1;
        dec_rw   = 1'b1;
        dec_m2r  = WB_DMEM;
        dec_size = strb;
        dec_uns  = funct3[2];
        // LD (011) and LWU (110) exist only on RV64; 111 has no load.
        if (funct3 == 3'b111) begin
          dec_ill = 1'b1;
        end else if ((funct3 == 3'b011 || funct3 == 3'b110) && XLEN != 64) begin
          dec_ill = 1'b1;
        end
      end
      OPC_STORE: begin
        dec_mw   = 1'b1;
        dec_size = strb;
        if (funct3[2]) begin
          dec_ill = 1'b1;
        end else if (funct3[1:0] == 2'b11 && XLEN != 64) begin
          dec_ill = 1'b1;
        end
      end
      OPC_JAL, OPC_JALR: begin
        dec_rw  = 1'b1;
        dec_m2r = WB_PC4;
      end
      OPC_AUIPC: dec_m2r = WB_ALU;
      OPC_LUI:   dec_m2r = WB_IMM;
      OPC_BRANCH: begin
        // Branches resolve in execute; no write-back or memory controls.
      end
      default: begin
`ifdef DECODE_PIM_DMA_EN
        if (opcode == PIM_OPCODE) begin
          dec_dma = 1'b1;
          dec_mw  = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
`else
        dec_ill = 1'b1;
`endif
      end
    endcase

    // An illegal encoding still travels downstream, but carries no side effects.
    if (dec_ill) begin
      dec_rw   = 1'b0;
      dec_mr   = 1'b0;
      dec_mw   = 1'b0;
      dec_size = '0;
      dec_uns  = 1'b0;
      dec_m2r  = WB_ALU;
      dec_md   = 1'b0;
      dec_dma  = 1'b0;
    end

    // Writes to x0 are architecturally discarded.
    if (rd == 5'd0) begin
      dec_rw = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and interlock state
  // ---------------------------------------------------------------------------
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] mdcnt_q, mdcnt_d;
  logic             dma_busy_q;
  logic             load;
  logic             xfer;
  logic             xfer_arm;

  logic              md_q, dma_q;
  logic [4:0]        rd_q, rs1_q;
  logic [2:0]        f3_q;
  logic              rw_q, mr_q, mw_q, uns_q, ill_q;
  logic [STRB_W-1:0] size_q;
  logic [2:0]        m2r_q;

  assign busy_o      = (mdcnt_q != '0) || dma_busy_q;
  assign out_valid_o = vld_q && !busy_o;
  assign in_ready_o  = !flush_i && (!vld_q || (out_valid_o && out_ready_i));

  assign load = in_valid_i && in_ready_o;
  assign xfer = out_valid_o && out_ready_i;
  // A flush wins over a same-cycle transfer, so a flushed command never
  // starts a unit and must not arm its interlock.
  assign xfer_arm = xfer && !flush_i;

  always_comb begin
    vld_d = vld_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = 1'b1;
    end else if (xfer) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    mdcnt_d = mdcnt_q;
    if (xfer_arm && md_q) begin
      mdcnt_d = CNT_W'(MULDIV_LAT);
    end else if (mdcnt_q != '0) begin
      mdcnt_d = mdcnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      mdcnt_q <= '0;
    end else begin
      vld_q   <= vld_d;
      mdcnt_q <= mdcnt_d;
    end
  end

`ifdef DECODE_PIM_DMA_EN
  logic dma_busy_d;

  // A new DMA issue in the same cycle as a completion pulse belongs to the
  // new command, so the set takes priority over the clear.
  always_comb begin
    dma_busy_d = dma_busy_q;
    if (xfer_arm && dma_q) begin
      dma_busy_d = 1'b1;
    end else if (dma_done_i) begin
      dma_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dma_busy_q <= 1'b0;
    end else begin
      dma_busy_q <= dma_busy_d;
    end
  end
`else
  logic unused_dma_done;
  assign unused_dma_done = dma_done_i;
  assign dma_busy_q      = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register: loaded only on acceptance, so it stays stable while
  // execute stalls.
  // ---------------------------------------------------------------------------
  logic [4:0]        rd_d, rs1_d;
  logic [2:0]        f3_d, m2r_d;
  logic              rw_d, mr_d, mw_d, uns_d, md_d, dma_d, ill_d;
  logic [STRB_W-1:0] size_d;

  always_comb begin
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    f3_d   = f3_q;
    rw_d   = rw_q;
    mr_d   = mr_q;
    mw_d   = mw_q;
    size_d = size_q;
    uns_d  = uns_q;
    m2r_d  = m2r_q;
    md_d   = md_q;
    dma_d  = dma_q;
    ill_d  = ill_q;
    if (load) begin
      rd_d   = rd;
      rs1_d  = rs1;
      f3_d   = funct3;
      rw_d   = dec_rw;
      mr_d   = dec_mr;
      mw_d   = dec_mw;
      size_d = dec_size;
      uns_d  = dec_uns;
      m2r_d  = dec_m2r;
      md_d   = dec_md;
      dma_d  = dec_dma;
      ill_d  = dec_ill;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= '0;
      rs1_q  <= '0;
      f3_q   <= '0;
      rw_q   <= 1'b0;
      mr_q   <= 1'b0;
      mw_q   <= 1'b0;
      size_q <= '0;
      uns_q  <= 1'b0;
      m2r_q  <= '0;
      md_q   <= 1'b0;
      dma_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      rs1_q  <= rs1_d;
      f3_q   <= f3_d;
      rw_q   <= rw_d;
      mr_q   <= mr_d;
      mw_q   <= mw_d;
      size_q <= size_d;
      uns_q  <= uns_d;
      m2r_q  <= m2r_d;
      md_q   <= md_d;
      dma_q  <= dma_d;
      ill_q  <= ill_d;
    end
  end

  assign rd_o         = rd_q;
  assign rs1_o        = rs1_q;
  assign funct3_o     = f3_q;
  assign reg_write_o  = rw_q;
  assign mem_read_o   = mr_q;
  assign mem_write_o  = mw_q;
  assign d_size_o     = size_q;
  assign d_unsigned_o = uns_q;
  assign mem_to_reg_o = m2r_q;
  assign muldiv_en_o  = md_q;
  assign dma_en_o     = dma_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//
// Bench for decode_stage. A 32-bit instance is checked through a scoreboard:
// every accepted instruction pushes its expected output vector and the monitor
// pops and compares on each downstream transfer. A 64-bit instance shares the
// same stimulus and is probed directly for the RV64-only encodings.
// Macro DECODE_PIM_DMA_EN selects the DMA sequence instead of the
// illegal-PIM vector.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  // ---------------------------------------------------------------------------
  // Clock / reset / signals
  // ---------------------------------------------------------------------------
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] instr_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        dma_done_i = 1'b0;
  logic        out_ready_i = 1'b0;

  logic       in_ready_o, out_valid_o, busy_o;
  logic [4:0] rd_o, rs1_o;
  logic [2:0] funct3_o, mem_to_reg_o;
  logic       reg_write_o, mem_read_o, mem_write_o, d_unsigned_o;
  logic [3:0] d_size_o;
  logic       muldiv_en_o, dma_en_o, illegal_o;

  logic       in_ready_64, out_valid_64, busy_64;
  logic [4:0] rd_64, rs1_64;
  logic [2:0] funct3_64, mem_to_reg_64;
  logic       reg_write_64, mem_read_64, mem_write_64, d_unsigned_64;
  logic [7:0] d_size_64;
  logic       muldiv_en_64, dma_en_64, illegal_64;

  always #5 clk_i = ~clk_i;

  decode_stage #(.XLEN(32), .MULDIV_LAT(4)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .instr_i(instr_i),
    .flush_i(flush_i), .dma_done_i(dma_done_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_o(rd_o), .rs1_o(rs1_o), .funct3_o(funct3_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .d_size_o(d_size_o), .d_unsigned_o(d_unsigned_o), .mem_to_reg_o(mem_to_reg_o),
    .muldiv_en_o(muldiv_en_o), .dma_en_o(dma_en_o), .illegal_o(illegal_o),
    .busy_o(busy_o)
  );

  decode_stage #(.XLEN(64), .MULDIV_LAT(4)) u_dut64 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_64), .instr_i(instr_i),
    .flush_i(flush_i), .dma_done_i(dma_done_i),
    .out_valid_o(out_valid_64), .out_ready_i(out_ready_i),
    .rd_o(rd_64), .rs1_o(rs1_64), .funct3_o(funct3_64),
    .reg_write_o(reg_write_64), .mem_read_o(mem_read_64), .mem_write_o(mem_write_64),
    .d_size_o(d_size_64), .d_unsigned_o(d_unsigned_64), .mem_to_reg_o(mem_to_reg_64),
    .muldiv_en_o(muldiv_en_64), .dma_en_o(dma_en_64), .illegal_o(illegal_64),
    .busy_o(busy_64)
  );

  // ---------------------------------------------------------------------------
  // Expected-value helpers
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];

  typedef struct {
    logic [31:0] instr;
    logic [13:0] ctl;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [13:0] mk(input logic rw, input logic mr, input logic mw,
                                     input logic [3:0] ds, input logic uns,
                                     input logic [2:0] m2r, input logic md,
                                     input logic dma, input logic ill);
    return {rw, mr, mw, ds, uns, m2r, md, dma, ill};
  endfunction

  function automatic logic [26:0] full(input logic [31:0] ins, input logic [13:0] ctl);
    return {ins[11:7], ins[19:15], ins[14:12], ctl};
  endfunction

  logic [26:0] got;
  assign got = {rd_o, rs1_o, funct3_o, reg_write_o, mem_read_o, mem_write_o,
                d_size_o, d_unsigned_o, mem_to_reg_o, muldiv_en_o, dma_en_o, illegal_o};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitor: compare on every downstream transfer
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin : monitor
    logic [26:0] e;
    if (rst_ni && out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out act=%0h exp=none", got);
      end else begin
        e = exp_q.pop_front();
        check("out_vec", {37'h0, got}, {37'h0, e});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [31:0] ins, input logic [26:0] exp);
    int n = 0;
    in_valid_i = 1'b1;
    instr_i    = ins;
    @(negedge clk_i);
    while (!in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (!in_ready_o) begin
      errors++;
      $display("FAIL accept_timeout act=in_ready_0 exp=in_ready_1 instr=%h", ins);
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain act=%0d_pending exp=0_pending", name, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_MUL  = 32'h022081B3;
  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h40208233;
  localparam logic [31:0] I_LUI  = 32'h00000537;
  localparam logic [31:0] I_LD   = 32'h0000B403;
  localparam logic [31:0] I_LWU  = 32'h0000E483;
  localparam logic [31:0] I_PIM  = 32'h0000000B;

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [13:0] c_ill;
    logic [13:0] c_add;
    logic [13:0] c_mul;
    c_ill = mk(0, 0, 0, 4'h0, 0, 3'b000, 0, 0, 1);
    c_add = mk(1, 0, 0, 4'h0, 0, 3'b000, 0, 0, 0);
    c_mul = mk(1, 0, 0, 4'h0, 0, 3'b101, 1, 0, 0);

    vecs.push_back('{32'h0000A283, mk(1, 1, 0, 4'hF, 0, 3'b001, 0, 0, 0)}); // lw x5
    vecs.push_back('{32'h00000013, mk(0, 0, 0, 4'h0, 0, 3'b000, 0, 0, 0)}); // addi x0
    vecs.push_back('{32'h0000007F, c_ill});                                  // unknown opcode
    vecs.push_back('{I_ADD,        c_add});                                  // add x3
    vecs.push_back('{32'h00014303, mk(1, 1, 0, 4'h1, 1, 3'b001, 0, 0, 0)}); // lbu x6
    vecs.push_back('{32'h00011383, mk(1, 1, 0, 4'h3, 0, 3'b001, 0, 0, 0)}); // lh x7
    vecs.push_back('{32'h0050A223, mk(0, 0, 1, 4'hF, 0, 3'b000, 0, 0, 0)}); // sw
    vecs.push_back('{I_LD,         c_ill});                                  // ld on RV32
    vecs.push_back('{I_LWU,        c_ill});                                  // lwu on RV32
    vecs.push_back('{32'h000000EF, mk(1, 0, 0, 4'h0, 0, 3'b010, 0, 0, 0)}); // jal x1
    vecs.push_back('{32'h000280E7, mk(1, 0, 0, 4'h0, 0, 3'b010, 0, 0, 0)}); // jalr x1
    vecs.push_back('{32'h00208063, mk(0, 0, 0, 4'h0, 0, 3'b000, 0, 0, 0)}); // beq
    vecs.push_back('{32'h0050C223, c_ill});                                  // store funct3 100
    vecs.push_back('{32'h0000F403, c_ill});                                  // load funct3 111
    vecs.push_back('{32'h00708293, c_add});                                  // addi x5
    vecs.push_back('{32'h00000517, mk(0, 0, 0, 4'h0, 0, 3'b000, 0, 0, 0)}); // auipc
    vecs.push_back('{I_LUI,        mk(0, 0, 0, 4'h0, 0, 3'b011, 0, 0, 0)}); // lui
    vecs.push_back('{32'h0000A003, mk(0, 1, 0, 4'hF, 0, 3'b001, 0, 0, 0)}); // lw x0
`ifndef DECODE_PIM_DMA_EN
    vecs.push_back('{I_PIM,        c_ill});                                  // PIM disabled
`endif

    // Reset state
    repeat (2) @(negedge clk_i);
    check("rst_out_valid", out_valid_o, 0);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_outputs", got, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Latency: lw accepted, valid on the next cycle
    out_ready_i = 1'b1;
    send(I_LW, full(I_LW, mk(1, 1, 0, 4'hF, 0, 3'b001, 0, 0, 0)));
    @(negedge clk_i);
    check("lw_latency_valid", out_valid_o, 1);
    @(posedge clk_i);
    #1;

    // Table, back-to-back
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].instr, full(vecs[i].instr, vecs[i].ctl));
    end
    wait_drain("table");

    // RV64-only loads on the 64-bit instance
    send(I_LD, full(I_LD, c_ill));
    @(negedge clk_i);
    check("ld64_valid", out_valid_64, 1);
    check("ld64_size", d_size_64, 8'hFF);
    check("ld64_illegal", illegal_64, 0);
    check("ld64_mem_read", mem_read_64, 1);
    @(posedge clk_i);
    #1;
    send(I_LWU, full(I_LWU, c_ill));
    @(negedge clk_i);
    check("lwu64_size", d_size_64, 8'h0F);
    check("lwu64_unsigned", d_unsigned_64, 1);
    check("lwu64_illegal", illegal_64, 0);
    @(posedge clk_i);
    #1;
    wait_drain("rv64");

    // MUL interlock: mul transfers at T, add presented at T+5
    in_valid_i = 1'b1;
    instr_i    = I_MUL;
    @(negedge clk_i);
    check("mul_accept", in_ready_o, 1);
    exp_q.push_back(full(I_MUL, c_mul));
    @(posedge clk_i);
    #1;
    instr_i = I_ADD;
    @(negedge clk_i);
    check("mul_T_valid", out_valid_o, 1);
    check("mul_T_muldiv", muldiv_en_o, 1);
    check("add_accept_T", in_ready_o, 1);
    exp_q.push_back(full(I_ADD, c_add));
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk_i);
      check($sformatf("mul_busy_T%0d", k), busy_o, 1);
      check($sformatf("mul_hold_T%0d", k), out_valid_o, 0);
    end
    @(negedge clk_i);
    check("add_valid_T5", out_valid_o, 1);
    check("busy_clear_T5", busy_o, 0);
    @(posedge clk_i);
    #1;
    wait_drain("mul");

`ifdef DECODE_PIM_DMA_EN
    // DMA interlock: next instruction held until the cycle after dma_done_i
    in_valid_i = 1'b1;
    instr_i    = I_PIM;
    @(negedge clk_i);
    exp_q.push_back(full(I_PIM, mk(0, 0, 1, 4'h0, 0, 3'b000, 0, 1, 0)));
    @(posedge clk_i);
    #1;
    instr_i = I_ADD;
    @(negedge clk_i);
    check("pim_dma_en", dma_en_o, 1);
    check("pim_mem_write", mem_write_o, 1);
    check("pim_add_accept", in_ready_o, 1);
    exp_q.push_back(full(I_ADD, c_add));
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i);
      check($sformatf("dma_hold_T%0d", k), out_valid_o, 0);
    end
    @(posedge clk_i);
    #1;
    dma_done_i = 1'b1;
    @(negedge clk_i);
    check("dma_done_cycle_hold", out_valid_o, 0);
    @(posedge clk_i);
    #1;
    dma_done_i = 1'b0;
    @(negedge clk_i);
    check("dma_release_valid", out_valid_o, 1);
    check("dma_release_busy", busy_o, 0);
    @(posedge clk_i);
    #1;
    wait_drain("dma");
`endif

    // Stall stability, then flush
    out_ready_i = 1'b0;
    send(I_SUB, full(I_SUB, c_add));
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1'b1;
      instr_i    = I_LUI;
      @(negedge clk_i);
      check("stall_valid", out_valid_o, 1);
      check("stall_stable", got, full(I_SUB, c_add));
      check("stall_in_ready", in_ready_o, 0);
      @(posedge clk_i);
      #1;
    end
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_in_ready", in_ready_o, 0);
    @(posedge clk_i);
    #1;
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk_i);
    check("flush_drop_valid", out_valid_o, 0);
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("flush_no_accept", out_valid_o, 0);
    end
    @(posedge clk_i);
    #1;

    // Reset asserted while an add waits behind a busy MUL/DIV unit
    send(I_MUL, full(I_MUL, c_mul));
    send(I_ADD, full(I_ADD, c_add));
    @(negedge clk_i);
    check("pre_reset_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("midrst_busy", busy_o, 0);
    check("midrst_out_valid", out_valid_o, 0);
    check("midrst_in_ready", in_ready_o, 1);
    check("midrst_outputs", got, 0);
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Recovery after reset
    send(I_ADD, full(I_ADD, c_add));
    wait_drain("recover");
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
